mc_ctrl: RTL

// - Multicycle successor to the single-cycle main decoder: Moore FSM sequencing RV32I subset (lw, sw, R, I-ALU, beq, jal).
// - Sits between instruction register (op) and multicycle datapath; drives PC/IR/mem/regfile enables and ALU/ext-unit selects.
// - Adds parametrised memory wait states, an I-ALU/jal path and a sticky illegal-opcode trap.

---
 rtl/mc_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multicycle Moore control FSM for an RV32I subset (lw, sw, R, I-ALU, beq, jal).
// Define MCCTRL_MEMRDY_EN so that memory states wait for mem_ready instead of MEM_WAIT cycles.
module mc_ctrl #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
`ifdef MCCTRL_MEMRDY_EN
  input  logic       mem_ready,
`endif
  output logic       pcupdate,
  output logic       branch,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluops,
  output logic [1:0] extnrops,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_ALUWB  = 4'd7,
    S_EXECI  = 4'd8,
    S_JAL    = 4'd9,
    S_BEQ    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             illegal_reg;
  logic             mem_state;
  logic             mem_done;

  assign mem_state = (state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                     (state_reg == S_MEMWR);

`ifdef MCCTRL_MEMRDY_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = (cnt_reg == CNT_W'(MEM_WAIT));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      cnt_reg     <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_reg | (state_next == S_TRAP);
      // Counter only runs while a memory state is stalled; any transition restarts it.
      if (state_next != state_reg)
        cnt_reg <= '0;
      else if (mem_state && !mem_done)
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  if (mem_done) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEMADR: state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_done) state_next = S_MEMWB;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  if (mem_done) state_next = S_FETCH;
      S_EXECR:  state_next = S_ALUWB;
      S_EXECI:  state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_JAL:    state_next = S_ALUWB;
      S_BEQ:    state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pcupdate  = 1'b0;
    branch    = 1'b0;
    adrsrc    = 1'b0;
    irwrite   = 1'b0;
    memwrite  = 1'b0;
    regwrite  = 1'b0;
    resultsrc = 2'b00;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    aluops    = 2'b00;
    extnrops  = 2'b00;
    case (op)
      OP_SW:   extnrops = 2'b01;
      OP_BEQ:  extnrops = 2'b10;
      OP_JAL:  extnrops = 2'b11;
      default: extnrops = 2'b00;
    endcase
    case (state_reg)
      S_FETCH: begin
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = mem_done;
        pcupdate  = mem_done;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMRD:  adrsrc = 1'b1;
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
      end
      S_MEMWR: begin
        adrsrc   = 1'b1;
        memwrite = mem_done;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluops  = 2'b10;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluops  = 2'b10;
      end
      S_ALUWB:  regwrite = 1'b1;
      S_JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      S_BEQ: begin
        alusrca = 2'b10;
        aluops  = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
    // Reset suppresses every strobe so an interrupted store/writeback never lands.
    if (rst) begin
      pcupdate  = 1'b0;
      branch    = 1'b0;
      adrsrc    = 1'b0;
      irwrite   = 1'b0;
      memwrite  = 1'b0;
      regwrite  = 1'b0;
      resultsrc = 2'b00;
      alusrca   = 2'b00;
      alusrcb   = 2'b00;
      aluops    = 2'b00;
      extnrops  = 2'b00;
    end
  end

  assign illegal = illegal_reg;
  assign state   = state_reg;

endmodule
